// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, default frame width and
// baud constants common with the baud-rate generator.
package uart_pkg;

    localparam int DEFAULT_DATA_BITS = 8;

    localparam int CLK_PERIOD_NS = 20;
    localparam int BAUD          = 9600;
    localparam int CLKS_PER_BIT  = 5208;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } rx_state_t;

    // Returns 1 when the data word holds an odd number of ones.
    function automatic logic odd_ones(input logic [7:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Serial-line synchronizer plus falling-edge detector; all flops reset to the
// line-idle value so a quiet line produces no spurious edge.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rs232_rx,
    output logic rx_s,
    output logic rx_fall
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Metastability chain followed by the previous-value flop for edge detect.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b1}};
            prev_r <= 1'b1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rs232_rx};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rx_s    = sync_r[SYNC_STAGES-1];
    assign rx_fall = prev_r & ~sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver driven by mid-bit ticks from the baud generator.
// Optional even-parity check is enabled with `define UART_RX_PARITY_EN.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = DEFAULT_DATA_BITS,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rs232_rx,
    input  logic                 clk_bps,
    output logic                 bps_start,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);

    localparam int IW = $clog2(DATA_BITS);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    rx_state_t              state_r;
    logic [IW-1:0]          idx_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   rx_s;
    logic                   rx_fall;
`ifdef UART_RX_PARITY_EN
    logic                   par_bad_r;
`endif

    uart_rx_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rs232_rx(rs232_rx),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    // Frame FSM: all outputs registered; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            idx_r     <= '0;
            shift_r   <= '0;
            bps_start <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_r  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (rx_fall) begin
                        state_r   <= START;
                        bps_start <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                START: begin
                    if (clk_bps) begin
                        if (!rx_s) begin
                            state_r <= DATA;
                            idx_r   <= '0;
                        end else begin
                            // Glitch shorter than half a bit: not a real start.
                            state_r   <= IDLE;
                            bps_start <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (clk_bps) begin
                        shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
                        idx_r   <= idx_r + IDX_ONE;
                        if (idx_r == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                            state_r <= PARITY;
`else
                            state_r <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (clk_bps) begin
                        par_bad_r <= odd_ones(8'(shift_r)) ^ rx_s;
                        state_r   <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (clk_bps) begin
                        if (rx_s) begin
                            rx_data  <= shift_r;
                            rx_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_err <= par_bad_r;
`endif
                        end else begin
                            frame_err <= 1'b1;
                        end
                        // Re-arm at mid-stop-bit so a back-to-back start edge is caught.
                        state_r   <= IDLE;
                        bps_start <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    bps_start <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame with a scaled-down baud generator model;
// parity cases build only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_frame;

    localparam int CPB  = 32;
    localparam int HALF = CPB / 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rs232_rx = 1'b1;
    logic       clk_bps;
    logic       bps_start;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int perr_cnt  = 0;
    int both_cnt  = 0;
    int lat_bad   = 0;
    logic prev_tick = 1'b0;
    int v0, f0, p0;

    logic [7:0] gen_cnt = 8'd0;

    uart_rx_frame #(
        .DATA_BITS  (8),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs232_rx (rs232_rx),
        .clk_bps  (clk_bps),
        .bps_start(bps_start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #10 clk = ~clk;

    // Baud generator model: counter cleared while bps_start is low, tick at mid-bit.
    always_ff @(posedge clk) begin
        if (!bps_start) begin
            gen_cnt <= 8'd0;
            clk_bps <= 1'b0;
        end else begin
            gen_cnt <= (gen_cnt == 8'(CPB - 1)) ? 8'd0 : gen_cnt + 8'd1;
            clk_bps <= (gen_cnt == 8'(HALF - 1));
        end
    end

    // Pulse monitor: counts strobes and checks latency and bps_start timing.
    always @(negedge clk) begin
        if (rx_valid) valid_cnt++;
        if (frame_err) ferr_cnt++;
        if (rx_valid && frame_err) both_cnt++;
        if ((rx_valid || frame_err) && (!prev_tick || bps_start)) lat_bad++;
`ifdef UART_RX_PARITY_EN
        if (parity_err) perr_cnt++;
`endif
        prev_tick = clk_bps;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic b);
        rs232_rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_tail(input logic [7:0] d, input logic par, input logic stop_bit);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par) rs232_rx = 1'b0;
`endif
        drive_bit(stop_bit);
        rs232_rx = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop_bit);
        drive_bit(1'b0);
        send_tail(d, par, stop_bit);
    endtask

    task automatic snap();
        v0 = valid_cnt;
        f0 = ferr_cnt;
        p0 = perr_cnt;
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check_val("rst_bps_start", 32'(bps_start), 32'd0);
        check_val("rst_busy",      32'(busy),      32'd0);
        check_val("rst_rx_data",   32'(rx_data),   32'd0);
        check_val("rst_pulses",    32'(rx_valid | frame_err), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single good frame 0x55
        snap();
        drive_bit(1'b0);
        check_val("frame_bps_start", 32'(bps_start), 32'd1);
        check_val("frame_busy",      32'(busy),      32'd1);
        send_tail(8'h55, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_val("x55_valid", 32'(valid_cnt - v0), 32'd1);
        check_val("x55_data",  32'(rx_data),        32'h55);
        check_val("x55_ferr",  32'(ferr_cnt - f0),  32'd0);
        check_val("x55_bps_low", 32'(bps_start),    32'd0);

        // Back-to-back 0xA3 then 0x0F with a single stop bit each
        snap();
        send_frame(8'hA3, 1'b0, 1'b1);
        check_val("b2b_first_valid", 32'(valid_cnt - v0), 32'd1);
        check_val("b2b_first_data",  32'(rx_data),        32'hA3);
        send_frame(8'h0F, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_val("b2b_valid", 32'(valid_cnt - v0), 32'd2);
        check_val("b2b_data",  32'(rx_data),        32'h0F);
        check_val("b2b_ferr",  32'(ferr_cnt - f0),  32'd0);

        // Bad stop bit on 0x81
        snap();
        send_frame(8'h81, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check_val("badstop_ferr",  32'(ferr_cnt - f0),  32'd1);
        check_val("badstop_valid", 32'(valid_cnt - v0), 32'd0);
        check_val("badstop_data",  32'(rx_data),        32'h0F);
        check_val("badstop_busy",  32'(busy),           32'd0);

        // Short low glitch: false start
        snap();
        rs232_rx = 1'b0;
        repeat (8) @(negedge clk);
        rs232_rx = 1'b1;
        repeat (4) @(negedge clk);
        check_val("glitch_bps_high", 32'(bps_start), 32'd1);
        repeat (CPB) @(negedge clk);
        check_val("glitch_bps_low", 32'(bps_start), 32'd0);
        check_val("glitch_busy",    32'(busy),      32'd0);
        check_val("glitch_pulses",  32'((valid_cnt - v0) + (ferr_cnt - f0)), 32'd0);

        // Reset in the middle of data bit 4 of 0xFF
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        repeat (HALF) @(negedge clk);
        snap();
        rst_n = 1'b0;
        @(negedge clk);
        check_val("midrst_bps",   32'(bps_start), 32'd0);
        check_val("midrst_busy",  32'(busy),      32'd0);
        check_val("midrst_data",  32'(rx_data),   32'd0);
        check_val("midrst_pulse", 32'(rx_valid | frame_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        check_val("midrst_no_pulse", 32'((valid_cnt - v0) + (ferr_cnt - f0)), 32'd0);
        send_frame(8'h12, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_val("after_rst_valid", 32'(valid_cnt - v0), 32'd1);
        check_val("after_rst_data",  32'(rx_data),        32'h12);

        // Line held low across reset release: exactly one frame error
        snap();
        rs232_rx = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (14 * CPB) @(negedge clk);
        check_val("break_ferr",  32'(ferr_cnt - f0),  32'd1);
        check_val("break_valid", 32'(valid_cnt - v0), 32'd0);
        check_val("break_busy",  32'(busy),           32'd0);
        rs232_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check_val("break_once", 32'(ferr_cnt - f0), 32'd1);

`ifdef UART_RX_PARITY_EN
        snap();
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check_val("par_ok_valid", 32'(valid_cnt - v0), 32'd1);
        check_val("par_ok_perr",  32'(perr_cnt - p0),  32'd0);
        snap();
        send_frame(8'h07, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check_val("par_bad_valid", 32'(valid_cnt - v0), 32'd1);
        check_val("par_bad_perr",  32'(perr_cnt - p0),  32'd1);
        check_val("par_bad_data",  32'(rx_data),        32'h07);
`endif

        check_val("valid_ferr_overlap", 32'(both_cnt), 32'd0);
        check_val("pulse_latency",      32'(lat_bad),  32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
Name: uart_rx_frame

Overview:
- UART receiver that consumes the baud-tick pulse from the team's baud-rate generator.
- Detects a start-bit falling edge on the serial line and raises bps_start so the generator begins counting.
- Samples each bit at mid-bit on every clk_bps pulse, assembles the byte LSB-first and checks the stop bit.
- Presents the received byte with a one-cycle valid strobe.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- SYNC_STAGES, 2, flops in the serial-line synchronizer (>=2).

Ports:
- clk  input  1  system clock (50 MHz nominal).
- rst_n  input  1  reset, synchronous, active-low.
- rs232_rx  input  1  asynchronous serial line; idles high.
- clk_bps  input  1  one-cycle mid-bit tick from the baud generator; valid only while bps_start=1.
- bps_start  output  1  held high for the whole frame; generator counter is cleared while low.
- rx_data  output  DATA_BITS  last good byte; holds until the next good frame.
- rx_valid  output  1  one-cycle pulse when rx_data is updated.
- frame_err  output  1  one-cycle pulse when the stop bit samples low.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - state=IDLE; bps_start=0; rx_data=0; rx_valid=0; frame_err=0; busy=0.
  - Synchronizer and edge flops load 1 (line-idle value).
- Synchronizer: rs232_rx passes through SYNC_STAGES flops, then one edge flop. A falling edge (prev=1, now=0) is detected 1 cycle after the synced value changes.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - Falling edge -> START; bps_start=1 from the next cycle.
  - clk_bps is ignored in IDLE.
- START:
  - On clk_bps, sample the synced line.
  - Line=0: go to DATA with bit index=0.
  - Line=1: false start; go to IDLE and drop bps_start; no output pulse.
- DATA:
  - On each clk_bps, shift the synced line into the MSB of the shift register (LSB-first frame). Index increments.
  - After sample DATA_BITS-1, go to STOP (or PARITY, see the optional feature).
- STOP: on clk_bps, sample the line.
  - Line=1: rx_data<=shift register and rx_valid=1 for exactly one cycle.
  - Line=0: frame_err=1 for one cycle; rx_data unchanged.
  - Either way: go to IDLE; bps_start=0 in the same cycle as the pulse.
- Latency: rx_valid/frame_err assert the cycle after the stop-bit clk_bps.
- Re-arm: IDLE is re-entered at mid-stop-bit, so a start edge immediately following the stop bit is caught. Back-to-back frames need no idle gap beyond one stop bit.
- No clk_bps arriving in START/DATA/STOP: the FSM waits indefinitely; no timeout.
- Line held low at reset release:
  - Sync flops load 1, so one falling edge is seen; that frame ends in frame_err.
  - No further start until the line returns high and falls again (break condition yields exactly one frame_err).
- Reset asserted mid-frame: abort immediately to the reset values. The partial byte is discarded; no pulse.
- Edges during START/DATA/STOP are ignored; sampling is only on clk_bps.
- rx_valid and frame_err are never high in the same cycle.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP; one clk_bps samples the parity bit.
  - Even parity: XOR of data bits and parity bit must be 0.
  - Adds output port parity_err (1 bit), pulsed in the same cycle as rx_valid when the check fails. rx_data is still updated.
  - A stop-bit failure gives frame_err only; parity_err is not reported for that frame.
- Undefined: no PARITY state, no parity_err port; the frame is DATA_BITS + start + stop.

Decomposition:
- Package uart_pkg:
  - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3, PARITY=4).
  - Default DATA_BITS.
  - Baud constants shared with the generator: CLK_PERIOD_NS=20, BAUD=9600, clocks-per-bit 5208.
- Sub-module uart_rx_sync: SYNC_STAGES synchronizer plus falling-edge detector. Outputs rx_s and rx_fall; resets to 1.

Test Plan:
- Bench setup: 50 MHz clk, baud generator instantiated, 5208 clocks/bit.
- Send 0x55 with a valid stop bit -> bps_start high during the frame; one rx_valid; rx_data=0x55; frame_err=0; bps_start low after the stop sample.
- Send 0xA3 then 0x0F back-to-back, one stop bit each -> two rx_valid pulses, rx_data 0xA3 then 0x0F, no frame_err.
- Send 0x81 with stop bit forced 0 -> one frame_err pulse; rx_data retains the previous value; rx_valid stays 0.
- 1000-clock low glitch on an idle line -> start-bit check sees 1; back to IDLE; no pulses; bps_start high for about 2605 clocks only.
- rst_n low during data bit 4 of 0xFF -> all outputs at reset values next cycle; a following 0x12 frame is received correctly.
- With UART_RX_PARITY_EN: send 0x07 with parity=1 -> rx_valid, parity_err=0. Send 0x07 with parity=0 -> rx_valid and parity_err in the same cycle, rx_data=0x07.
